// File: rtl/i2c_reg_slave.sv
// I2C target exposing NUM_REGS control registers (e.g. PID gains).
// Supports auto-increment writes/reads, repeated START and open-drain SDA drive.
//
// state     | meaning
// IDLE      | bus free or block disabled
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | acknowledging our address
// REG       | shifting in register pointer
// REG_ACK   | acknowledging a valid pointer
// WDATA     | shifting in write data
// WDATA_ACK | acknowledging write data
// RDATA     | driving pointed register out, MSB first
// RDATA_ACK | sampling master ACK/NACK
// WAIT_STOP | not addressed or NACKed; ignore bits until STOP/START
`timescale 1ns/1ps
module i2c_reg_slave #(
    parameter logic [6:0]        DEVICE_ADDR = 7'h33,
    parameter int                NUM_REGS    = 3,
    parameter int                DATA_W      = 6,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         scl_in,
    input  logic                         sda_in,
    output logic                         sda_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [3:0]                   wr_index,
    output logic                         busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    localparam int         REGS_W     = NUM_REGS * DATA_W;
    localparam logic [3:0] LAST_REG   = 4'(NUM_REGS - 1);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                    scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [6:0]              shift_q, shift_d;
    logic                    rw_q, rw_d, ack_phase_q, ack_phase_d;
    logic [3:0]              pointer_q, pointer_d, wr_index_q, wr_index_d;
    logic [REGS_W-1:0]       regs_q, regs_d;
    logic                    sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in, rd_byte;
    logic [3:0] pointer_inc;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
        // SDA edges only count as bus conditions while SCL is stably high
        start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        byte_in    = {shift_q, sda_s};
        pointer_inc = (pointer_q == LAST_REG) ? 4'd0 : pointer_q + 4'd1;
    end

    always_comb begin
        rd_byte = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (pointer_q == 4'(r)) rd_byte[DATA_W-1:0] = regs_q[r*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ack_phase_d = ack_phase_q;
        pointer_d   = pointer_q;
        regs_d      = regs_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        if (!ena || stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd7;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        rw_d        = byte_in[0];
                        ack_phase_d = 1'b0;
                        state_d     = (byte_in[7:1] == DEVICE_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                REG: if (scl_rise) begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        ack_phase_d = 1'b0;
                        if (byte_in < NUM_REGS_B) begin
                            pointer_d = byte_in[3:0];
                            state_d   = REG_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        for (int r = 0; r < NUM_REGS; r++) begin
                            if (pointer_q == 4'(r)) regs_d[r*DATA_W +: DATA_W] = byte_in[DATA_W-1:0];
                        end
                        wr_strobe_d = 1'b1;
                        wr_index_d  = pointer_q;
                        pointer_d   = pointer_inc;
                        ack_phase_d = 1'b0;
                        state_d     = WDATA_ACK;
                    end
                end
                // first fall after the byte asserts ACK, the fall after the 9th rise releases it
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_rise) ack_phase_d = 1'b1;
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d = 1'b1;
                        end else if (state_q == ADDR_ACK && rw_q) begin
                            state_d  = RDATA;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = (state_q == ADDR_ACK) ? REG : WDATA;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) sda_oe_d = ~rd_byte[bit_cnt_q];
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) state_d = RDATA_ACK;
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        if (!sda_s) begin
                            pointer_d = pointer_inc;
                            state_d   = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
        busy_d = (state_d != IDLE) && (state_d != WAIT_STOP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd7;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            pointer_q   <= '0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            pointer_q   <= pointer_d;
            regs_q      <= regs_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master on a wired-AND SDA line,
// checked against a transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_i2c_reg_slave;

    localparam int         NUM_REGS = 3;
    localparam int         DATA_W   = 6;
    localparam logic [6:0] DEV      = 7'h33;

    logic clk = 1'b0;
    logic rst_n, ena, scl_m, sda_m, sda_bus;
    logic sda_oe, wr_strobe, busy;
    logic [3:0] wr_index;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] m_regs [NUM_REGS];
    int m_ptr;

    int strobe_idx[$];
    int oe_cnt = 0;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_reg_slave #(.DEVICE_ADDR(DEV), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_idx.push_back(int'(wr_index));
        if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    function automatic int model_wr(input logic [7:0] b);
        int idx = m_ptr;
        m_regs[m_ptr] = b[DATA_W-1:0];
        m_ptr = (m_ptr + 1) % NUM_REGS;
        return idx;
    endfunction

    function automatic logic [7:0] model_rd(input logic master_ack);
        logic [7:0] v = 8'(m_regs[m_ptr]);
        if (master_ack) m_ptr = (m_ptr + 1) % NUM_REGS;
        return v;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;
        m_ptr = 0;
    endfunction

    // ---------------- bus master ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(6); sda_m = 1'b0; tick(6); scl_m = 1'b0; tick(4);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(4); scl_m = 1'b1; tick(6); sda_m = 1'b1; tick(8);
    endtask

    task automatic bus_bit(input logic b, output logic seen);
        sda_m = b; tick(4); scl_m = 1'b1; tick(4); seen = sda_bus; tick(4); scl_m = 1'b0; tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        acked = (s === 1'b0);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d, output logic oe_at_ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        sda_m = ~master_ack; tick(4); scl_m = 1'b1; tick(4); oe_at_ack = sda_oe; tick(4); scl_m = 1'b0; tick(4);
    endtask

    task automatic do_write(input logic [7:0] reg_a, input logic [7:0] data[$], output logic all_ack);
        logic a;
        bus_start();
        send_byte({DEV, 1'b0}, a); all_ack = a;
        send_byte(reg_a, a);       all_ack &= a;
        foreach (data[i]) begin
            send_byte(data[i], a);
            all_ack &= a;
        end
        bus_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(2);
        model_reset();
        vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (wr_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
        vectors++; if (wr_index !== 4'd0) begin miscompares++; $display("FAIL reset_wr_index: got %0d expected 0", wr_index); end
        for (int r = 0; r < NUM_REGS; r++) begin
            vectors++;
            if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                miscompares++; $display("FAIL reset_reg%0d: got %0h expected %0h", r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
            end
        end
    endtask

    task automatic test_write_single();
        logic a0, a1, a2;
        int s0 = strobe_idx.size();
        int exp_idx;
        bus_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ws_busy_after_start: got %b expected 1", busy); end
        send_byte(8'h66, a0); send_byte(8'h01, a1); send_byte(8'hA5, a2);
        bus_stop(); tick(4);
        m_ptr = 1; exp_idx = model_wr(8'hA5);
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL ws_acks: got %b expected 111", {a0, a1, a2}); end
        vectors++; if (regs_flat[1*DATA_W +: DATA_W] !== 6'h25) begin miscompares++; $display("FAIL ws_reg1: got %0h expected 25", regs_flat[1*DATA_W +: DATA_W]); end
        for (int r = 0; r < NUM_REGS; r++) begin
            vectors++;
            if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                miscompares++; $display("FAIL ws_reg%0d: got %0h expected %0h", r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
            end
        end
        vectors++;
        if (strobe_idx.size() - s0 != 1) begin
            miscompares++; $display("FAIL ws_strobe_count: got %0d expected 1", strobe_idx.size() - s0);
        end else if (strobe_idx[s0] != exp_idx) begin
            miscompares++; $display("FAIL ws_strobe_index: got %0d expected %0d", strobe_idx[s0], exp_idx);
        end
        vectors++; if (wr_index !== 4'(exp_idx)) begin miscompares++; $display("FAIL ws_wr_index: got %0d expected %0d", wr_index, exp_idx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ws_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_autoinc_wrap();
        logic ok;
        logic [7:0] q[$];
        int exp_idx[$];
        int s0 = strobe_idx.size();
        q = '{8'h11, 8'h22};
        do_write(8'h02, q, ok); tick(4);
        m_ptr = 2;
        foreach (q[i]) exp_idx.push_back(model_wr(q[i]));
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wrap_acks: got %b expected 1", ok); end
        for (int r = 0; r < NUM_REGS; r++) begin
            vectors++;
            if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                miscompares++; $display("FAIL wrap_reg%0d: got %0h expected %0h", r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
            end
        end
        vectors++;
        if (strobe_idx.size() - s0 != exp_idx.size()) begin
            miscompares++; $display("FAIL wrap_strobe_count: got %0d expected %0d", strobe_idx.size() - s0, exp_idx.size());
        end else begin
            foreach (exp_idx[i]) begin
                vectors++;
                if (strobe_idx[s0+i] != exp_idx[i]) begin
                    miscompares++; $display("FAIL wrap_strobe_index%0d: got %0d expected %0d", i, strobe_idx[s0+i], exp_idx[i]);
                end
            end
        end
    endtask

    task automatic test_read_rsp();
        logic ok, a0, a1, a2, oe_ack;
        logic [7:0] d, exp;
        logic [7:0] q[$];
        q = '{8'h3F};
        do_write(8'h00, q, ok); tick(4);
        m_ptr = 0; void'(model_wr(8'h3F));
        bus_start();
        send_byte(8'h66, a0); send_byte(8'h00, a1);
        bus_start();
        send_byte(8'h67, a2);
        recv_byte(1'b0, d, oe_ack);
        bus_stop(); tick(4);
        m_ptr = 0; exp = model_rd(1'b0);
        vectors++; if ({ok, a0, a1, a2} !== 4'b1111) begin miscompares++; $display("FAIL rd_acks: got %b expected 1111", {ok, a0, a1, a2}); end
        vectors++; if (d !== exp) begin miscompares++; $display("FAIL rd_byte: got %0h expected %0h", d, exp); end
        vectors++; if (oe_ack !== 1'b0) begin miscompares++; $display("FAIL rd_oe_in_ack_slot: got %b expected 0", oe_ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_after_stop: got %b expected 0", busy); end
        vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL rd_sda_oe_after_stop: got %b expected 0", sda_oe); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1, a2;
        int oe0 = oe_cnt;
        int s0 = strobe_idx.size();
        bus_start();
        send_byte(8'h50, a0); send_byte(8'h01, a1); send_byte(8'h2A, a2);
        bus_stop(); tick(4);
        vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL mm_acks: got %b expected 000", {a0, a1, a2}); end
        vectors++; if (oe_cnt != oe0) begin miscompares++; $display("FAIL mm_sda_oe_cycles: got %0d expected 0", oe_cnt - oe0); end
        vectors++; if (strobe_idx.size() != s0) begin miscompares++; $display("FAIL mm_strobes: got %0d expected 0", strobe_idx.size() - s0); end
        for (int r = 0; r < NUM_REGS; r++) begin
            vectors++;
            if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                miscompares++; $display("FAIL mm_reg%0d: got %0h expected %0h", r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mm_busy: got %b expected 0", busy); end
    endtask

    task automatic test_invalid_reg();
        logic a0, a1, a2, b0, b1, b2;
        int s0 = strobe_idx.size();
        int s1;
        bus_start();
        send_byte(8'h66, a0); send_byte(8'h07, a1); send_byte(8'h15, a2);
        vectors++; if ({a0, a1, a2} !== 3'b100) begin miscompares++; $display("FAIL inv_acks: got %b expected 100", {a0, a1, a2}); end
        vectors++; if (strobe_idx.size() != s0) begin miscompares++; $display("FAIL inv_strobes: got %0d expected 0", strobe_idx.size() - s0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL inv_busy_after_nack: got %b expected 0", busy); end
        s1 = strobe_idx.size();
        bus_start();
        send_byte(8'h66, b0); send_byte(8'h01, b1); send_byte(8'h2A, b2);
        bus_stop(); tick(4);
        m_ptr = 1; void'(model_wr(8'h2A));
        vectors++; if ({b0, b1, b2} !== 3'b111) begin miscompares++; $display("FAIL inv_recover_acks: got %b expected 111", {b0, b1, b2}); end
        vectors++; if (strobe_idx.size() - s1 != 1) begin miscompares++; $display("FAIL inv_recover_strobes: got %0d expected 1", strobe_idx.size() - s1); end
        for (int r = 0; r < NUM_REGS; r++) begin
            vectors++;
            if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                miscompares++; $display("FAIL inv_reg%0d: got %0h expected %0h", r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
            end
        end
    endtask

    task automatic test_abort(input logic use_rst);
        logic a0, a1, s, ok;
        logic [7:0] q[$];
        int s0 = strobe_idx.size();
        bus_start();
        send_byte(8'h66, a0); send_byte(8'h02, a1);
        m_ptr = 2;
        for (int i = 7; i >= 4; i--) bus_bit(1'($urandom_range(0, 1)), s);
        if (use_rst) begin
            rst_n = 1'b0; tick(2);
            model_reset();
        end else begin
            ena = 1'b0; tick(2);
        end
        vectors++; if ({a0, a1} !== 2'b11) begin miscompares++; $display("FAIL abort%0d_acks: got %b expected 11", use_rst, {a0, a1}); end
        vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL abort%0d_sda_oe: got %b expected 0", use_rst, sda_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort%0d_busy: got %b expected 0", use_rst, busy); end
        vectors++; if (strobe_idx.size() != s0) begin miscompares++; $display("FAIL abort%0d_strobes: got %0d expected 0", use_rst, strobe_idx.size() - s0); end
        for (int r = 0; r < NUM_REGS; r++) begin
            vectors++;
            if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                miscompares++; $display("FAIL abort%0d_reg%0d: got %0h expected %0h", use_rst, r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
            end
        end
        rst_n = 1'b1; ena = 1'b1; tick(2);
        bus_stop();
        q = '{8'($urandom)};
        do_write(8'h02, q, ok); tick(4);
        m_ptr = 2; void'(model_wr(q[0]));
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL abort%0d_follow_acks: got %b expected 1", use_rst, ok); end
        for (int r = 0; r < NUM_REGS; r++) begin
            vectors++;
            if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                miscompares++; $display("FAIL abort%0d_follow_reg%0d: got %0h expected %0h", use_rst, r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int mode, reg_a, n, s0;
            logic ok, a, oe_ack, exp_ok;
            logic [7:0] d, exp;
            logic [7:0] q[$];
            int exp_idx[$];
            q.delete(); exp_idx.delete();
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                reg_a = $urandom_range(0, NUM_REGS + 1);
                n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) q.push_back(8'($urandom));
                s0 = strobe_idx.size();
                do_write(8'(reg_a), q, ok); tick(4);
                exp_ok = (reg_a < NUM_REGS);
                if (exp_ok) begin
                    m_ptr = reg_a;
                    foreach (q[j]) exp_idx.push_back(model_wr(q[j]));
                end
                vectors++; if (ok !== exp_ok) begin miscompares++; $display("FAIL rnd%0d_wr_acks: got %b expected %b", it, ok, exp_ok); end
                vectors++;
                if (strobe_idx.size() - s0 != exp_idx.size()) begin
                    miscompares++; $display("FAIL rnd%0d_strobe_count: got %0d expected %0d", it, strobe_idx.size() - s0, exp_idx.size());
                end else begin
                    foreach (exp_idx[j]) begin
                        vectors++;
                        if (strobe_idx[s0+j] != exp_idx[j]) begin
                            miscompares++; $display("FAIL rnd%0d_strobe_index%0d: got %0d expected %0d", it, j, strobe_idx[s0+j], exp_idx[j]);
                        end
                    end
                end
                for (int r = 0; r < NUM_REGS; r++) begin
                    vectors++;
                    if (regs_flat[r*DATA_W +: DATA_W] !== m_regs[r]) begin
                        miscompares++; $display("FAIL rnd%0d_reg%0d: got %0h expected %0h", it, r, regs_flat[r*DATA_W +: DATA_W], m_regs[r]);
                    end
                end
            end else begin
                n = $urandom_range(1, 4);
                ok = 1'b1;
                bus_start();
                if (mode == 1) begin
                    reg_a = $urandom_range(0, NUM_REGS - 1);
                    send_byte(8'h66, a); ok &= a;
                    send_byte(8'(reg_a), a); ok &= a;
                    bus_start();
                    m_ptr = reg_a;
                end
                send_byte({DEV, 1'b1}, a); ok &= a;
                for (int j = 0; j < n; j++) begin
                    recv_byte(j < n - 1, d, oe_ack);
                    exp = model_rd(j < n - 1);
                    vectors++;
                    if (d !== exp) begin miscompares++; $display("FAIL rnd%0d_rd_byte%0d: got %0h expected %0h", it, j, d, exp); end
                    vectors++;
                    if (oe_ack !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_rd_oe_ack%0d: got %b expected 0", it, j, oe_ack); end
                end
                bus_stop(); tick(4);
                vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_rd_acks: got %b expected 1", it, ok); end
            end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_busy_after_stop: got %b expected 0", it, busy); end
        end
    endtask

    initial begin
        scl_m = 1'b1; sda_m = 1'b1; ena = 1'b1; rst_n = 1'b0;
        test_reset();
        test_write_single();
        test_autoinc_wrap();
        test_read_rsp();
        test_addr_mismatch();
        test_invalid_reg();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
